// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_pkg
// Description : Shared constants, state encoding and font helpers for the
//               four-digit seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    localparam int N_DIG = 4;

    // Active-low segment patterns, bit7 = DP, [6:0] = g..a
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_GAP = 2'd1,
        S_ON  = 2'd2
    } state_t;

    // Segment pattern for one BCD nibble; non-decimal codes show nothing
    function automatic logic [7:0] seg_of(input logic [3:0] nib);
        logic [7:0] f;
        case (nib)
            4'd0:    f = FONT_0;
            4'd1:    f = FONT_1;
            4'd2:    f = FONT_2;
            4'd3:    f = FONT_3;
            4'd4:    f = FONT_4;
            4'd5:    f = FONT_5;
            4'd6:    f = FONT_6;
            4'd7:    f = FONT_7;
            4'd8:    f = FONT_8;
            4'd9:    f = FONT_9;
            default: f = FONT_BLANK;
        endcase
        return f;
    endfunction

    // Full pattern for digit idx, including leading-zero blanking and DP.
    // The DP is lit even on a blanked digit so a bare point can be shown.
    function automatic logic [7:0] digit_font(input logic [15:0] digits,
                                              input logic [3:0]  dp,
                                              input logic        lzb,
                                              input logic [1:0]  idx);
        logic [7:0] f;
        logic       blank;
        case (idx)
            2'd1:    blank = lzb && (digits[15:4]  == 12'd0);
            2'd2:    blank = lzb && (digits[15:8]  == 8'd0);
            2'd3:    blank = lzb && (digits[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        f = blank ? FONT_BLANK : seg_of(digits[{idx, 2'b00} +: 4]);
        if (dp[idx]) begin
            f[7] = 1'b0;
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : fnd_slot_timer
// Description : Per-digit slot counter; flags the last blank cycle and the
//               last cycle of each SCAN_DIV-long slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_slot_timer #(
    parameter int SCAN_DIV = 100000,
    parameter int GAP_CYC  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic gap_end,
    output logic slot_end
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    // Free-running slot count, held at zero while the scan is stopping or off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign gap_end  = run && (cnt == CW'(GAP_CYC - 1));
    assign slot_end = run && (cnt == CW'(SCAN_DIV - 1));

endmodule
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_ctrl
// Description : Four-digit multiplexed seven-segment scanner with blanking
//               gaps, leading-zero suppression and frame-synchronous loads.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GAP_CYC  = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    input  logic        i_lzb,
    output logic        o_busy,
    output logic        o_ack,
    output logic [3:0]  o_com,
    output logic [7:0]  o_font,
    output logic        o_frame
);

    state_t      state;
    logic [1:0]  idx;
    logic [3:0]  com;
    logic [7:0]  font;

    logic [15:0] stg_digits;
    logic [3:0]  stg_dp;
    logic        stg_lzb;
    logic [15:0] disp_digits;
    logic [3:0]  disp_dp;
    logic        disp_lzb;
    logic        busy;
    logic        ack;

    logic        run;
    logic        clear;
    logic        gap_end;
    logic        slot_end;
    logic        frame;

    assign run   = (state != S_OFF);
    assign clear = !run || !i_en;

    fnd_slot_timer #(
        .SCAN_DIV (SCAN_DIV),
        .GAP_CYC  (GAP_CYC)
    ) u_slot_timer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .run      (run),
        .clear    (clear),
        .gap_end  (gap_end),
        .slot_end (slot_end)
    );

    // Last cycle of the digit3 lit phase closes the frame
    assign frame = (state == S_ON) && (idx == 2'd3) && slot_end;

    // Scan FSM; commons and segments are updated on the same edge as the state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_OFF;
            idx   <= 2'd0;
            com   <= 4'hF;
            font  <= FONT_BLANK;
        end else if (!i_en) begin
            state <= S_OFF;
            idx   <= 2'd0;
            com   <= 4'hF;
            font  <= FONT_BLANK;
        end else begin
            case (state)
                S_OFF: begin
                    state <= S_GAP;
                    idx   <= 2'd0;
                    com   <= 4'hF;
                    font  <= FONT_BLANK;
                end
                S_GAP: begin
                    if (gap_end) begin
                        state <= S_ON;
                        com   <= ~(4'b0001 << idx);
                        font  <= digit_font(disp_digits, disp_dp, disp_lzb, idx);
                    end
                end
                S_ON: begin
                    if (slot_end) begin
                        state <= S_GAP;
                        idx   <= idx + 2'd1;
                        com   <= 4'hF;
                        font  <= FONT_BLANK;
                    end
                end
                default: begin
                    state <= S_OFF;
                    idx   <= 2'd0;
                    com   <= 4'hF;
                    font  <= FONT_BLANK;
                end
            endcase
        end
    end

    // Load handshake: stage on request, commit at frame boundary (or at once when off)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stg_digits  <= 16'd0;
            stg_dp      <= 4'd0;
            stg_lzb     <= 1'b0;
            disp_digits <= 16'd0;
            disp_dp     <= 4'd0;
            disp_lzb    <= 1'b0;
            busy        <= 1'b0;
            ack         <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (busy && ((state == S_OFF) || frame)) begin
                disp_digits <= stg_digits;
                disp_dp     <= stg_dp;
                disp_lzb    <= stg_lzb;
                busy        <= 1'b0;
                ack         <= 1'b1;
            end else if (i_load && !busy) begin
                stg_digits <= i_digits;
                stg_dp     <= i_dp;
                stg_lzb    <= i_lzb;
                busy       <= 1'b1;
            end
        end
    end

    assign o_busy  = busy;
    assign o_ack   = ack;
    assign o_com   = com;
    assign o_font  = font;
    assign o_frame = frame;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_scan_ctrl
// Description : Self-checking bench for fnd_scan_ctrl (SCAN_DIV=8, GAP_CYC=2)
//               with a frame-position reference model and a font table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_ctrl;

    localparam int SCAN_DIV = 8;
    localparam int GAP_CYC  = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] digits = 16'd0;
    logic [3:0]  dp     = 4'd0;
    logic        lzb    = 1'b0;
    logic        busy;
    logic        ack;
    logic [3:0]  com;
    logic [7:0]  font;
    logic        frame;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_load   (load),
        .i_digits (digits),
        .i_dp     (dp),
        .i_lzb    (lzb),
        .o_busy   (busy),
        .o_ack    (ack),
        .o_com    (com),
        .o_font   (font),
        .o_frame  (frame)
    );

    // Reference model: position within the frame plus display/staging values
    bit          m_active;
    int          m_t;
    bit          m_busy;
    bit          m_ack;
    logic [15:0] m_sd, m_dd;
    logic [3:0]  m_sdp, m_ddp;
    bit          m_slz, m_dlz;

    logic [7:0]  got [4];

    function automatic logic [7:0] ref_seg(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] ref_font(input int k);
        int         val;
        logic [7:0] f;
        val = int'(m_dd);
        if (k > 0 && m_dlz && (val >> (4 * k)) == 0) f = 8'hFF;
        else f = ref_seg((val >> (4 * k)) % 16);
        if (m_ddp[k]) f = f & 8'h7F;
        return f;
    endfunction

    task automatic model_reset();
        m_active = 0; m_t = 0; m_busy = 0; m_ack = 0;
        m_sd = 0; m_dd = 0; m_sdp = 0; m_ddp = 0; m_slz = 0; m_dlz = 0;
    endtask

    task automatic model_step();
        bit frame_old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        frame_old = m_active && (m_t == FRAME - 1);
        m_ack = 0;
        if (m_busy && (!m_active || frame_old)) begin
            m_dd = m_sd; m_ddp = m_sdp; m_dlz = m_slz; m_busy = 0; m_ack = 1;
        end else if (load && !m_busy) begin
            m_sd = digits; m_sdp = dp; m_slz = lzb; m_busy = 1;
        end
        if (!en) begin
            m_active = 0; m_t = 0;
        end else if (!m_active) begin
            m_active = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got_v, exp_v, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] ec;
        logic [7:0] ef;
        int         k;
        ec = 4'hF;
        ef = 8'hFF;
        if (m_active && (m_t % SCAN_DIV) >= GAP_CYC) begin
            k  = m_t / SCAN_DIV;
            ec = 4'hF & ~(4'b0001 << k);
            ef = ref_font(k);
        end
        check("com", {28'd0, com}, {28'd0, ec});
        check("font", {24'd0, font}, {24'd0, ef});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("ack", {31'd0, ack}, {31'd0, m_ack});
        check("frame", {31'd0, frame}, {31'd0, (m_active && m_t == FRAME - 1)});
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later
    task automatic tick(input bit e, input bit l, input logic [15:0] d,
                        input logic [3:0] p, input bit z);
        @(negedge clk);
        en = e; load = l; digits = d; dp = p; lzb = z;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle(input bit e);
        tick(e, 1'b0, 16'd0, 4'd0, 1'b0);
    endtask

    // Runs one full frame and records the pattern shown on each digit
    task automatic grab_frame();
        for (int k = 0; k < 4; k++) got[k] = 8'h00;
        repeat (FRAME) begin
            idle(1'b1);
            for (int k = 0; k < 4; k++) if (com[k] === 1'b0) got[k] = font;
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        bit          z;
        bit          dup;
        logic [7:0]  f [4];
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        int gap;

        tbl[0] = '{16'h1234, 4'b0100, 1'b0, 1'b1, '{8'h99, 8'hB0, 8'h24, 8'hF9}};
        tbl[1] = '{16'h0050, 4'b0000, 1'b1, 1'b0, '{8'hC0, 8'h92, 8'hFF, 8'hFF}};
        tbl[2] = '{16'h9876, 4'b0000, 1'b0, 1'b0, '{8'h82, 8'hF8, 8'h80, 8'h90}};
        tbl[3] = '{16'h000A, 4'b1000, 1'b1, 1'b0, '{8'hFF, 8'hFF, 8'hFF, 8'h7F}};
        tbl[4] = '{16'h0105, 4'b0001, 1'b1, 1'b0, '{8'h12, 8'hC0, 8'hF9, 8'hFF}};
        tbl[5] = '{16'h0000, 4'b0000, 1'b1, 1'b0, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};

        model_reset();

        // Reset state, then release mid-cycle
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;

        // First slot after enable: two blank cycles then digit0 showing 0
        for (int i = 0; i < SCAN_DIV; i++) begin
            idle(1'b1);
            check("slot0_com", {28'd0, com}, (i < GAP_CYC) ? 32'hF : 32'hE);
            check("slot0_font", {24'd0, font}, (i < GAP_CYC) ? 32'hFF : 32'hC0);
        end

        // Frame period
        n = 0;
        while (frame !== 1'b1 && n < 2 * FRAME) begin idle(1'b1); n++; end
        gap = 0;
        do begin idle(1'b1); gap++; end while (frame !== 1'b1 && gap < 2 * FRAME);
        check("frame_period", gap, FRAME);

        // Table of loads with per-digit expected patterns
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(3, 20)) idle(1'b1);
            tick(1'b1, 1'b1, tbl[i].d, tbl[i].p, tbl[i].z);
            check("busy_after_load", {31'd0, busy}, 32'd1);
            if (tbl[i].dup) tick(1'b1, 1'b1, 16'h9999, 4'hF, 1'b1);
            n = 0;
            while (ack !== 1'b1 && n < 3 * FRAME) begin idle(1'b1); n++; end
            check("ack_seen", {31'd0, ack}, 32'd1);
            grab_frame();
            for (int k = 0; k < 4; k++) check("table_font", {24'd0, got[k]}, {24'd0, tbl[i].f[k]});
        end

        // Load arriving on the frame cycle waits for the next frame
        n = 0;
        while (!(m_active && m_t == FRAME - 1) && n < 2 * FRAME) begin idle(1'b1); n++; end
        tick(1'b1, 1'b1, 16'h4321, 4'h0, 1'b0);
        n = 0;
        while (ack !== 1'b1 && n < 3 * FRAME) begin idle(1'b1); n++; end
        check("frame_load_latency", n, FRAME);

        // Load while scan is off commits right away; re-enable shows it
        repeat (3) idle(1'b0);
        tick(1'b0, 1'b1, 16'h0007, 4'h0, 1'b0);
        check("off_busy", {31'd0, busy}, 32'd1);
        idle(1'b0);
        check("off_ack", {31'd0, ack}, 32'd1);
        check("off_com", {28'd0, com}, 32'hF);
        idle(1'b1);
        grab_frame();
        check("reenable_digit0", {24'd0, got[0]}, 32'hF8);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                 16'($urandom), 4'($urandom), 1'($urandom));
        end

        // Asynchronous reset while lit with a load pending
        repeat (2) idle(1'b1);
        n = 0;
        while (!(m_active && m_t == 3) && n < 2 * FRAME) begin idle(1'b1); n++; end
        tick(1'b1, 1'b1, 16'h5555, 4'h0, 1'b0);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        check("pre_reset_lit", {31'd0, (com != 4'hF)}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_com", {28'd0, com}, 32'hF);
        check("async_font", {24'd0, font}, 32'hFF);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_ack", {31'd0, ack}, 32'd0);
        check("async_frame", {31'd0, frame}, 32'd0);
        repeat (3) idle(1'b1);
        rst_n = 1'b1;
        repeat (2 * FRAME) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
